// File: rtl/uart_pkg.sv
// Shared types and constants for the knight-side UART command link.
package uart_pkg;

    localparam int         BAUD_DIV_DEFAULT = 434;  // 50 MHz / 115200 baud
    localparam logic [7:0] POS_ACK          = 8'hA5;

    typedef enum logic {HIGH = 1'b0, LOW = 1'b1} rx_asm_t;
    typedef enum logic {IDLE = 1'b0, TXING = 1'b1} tx_state_t;
    typedef enum logic {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_t;

endpackage

// File: rtl/UART.sv
// Full-duplex UART: independent receive and transmit paths sharing a baud divisor.
module UART
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_tx,
    output logic [7:0] o_rx_data,
    output logic       o_rdy,
    input  logic       i_clr_rdy,
    output logic       o_start,
    input  logic       i_trmt,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_done
);

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rx      (i_rx),
        .i_clr_rdy (i_clr_rdy),
        .o_rx_data (o_rx_data),
        .o_rdy     (o_rdy),
        .o_start   (o_start)
    );

    uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_trmt    (i_trmt),
        .i_tx_data (i_tx_data),
        .o_tx      (o_tx),
        .o_tx_done (o_tx_done)
    );

endmodule

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, stop-bit framing check.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    input  logic       i_clr_rdy,
    output logic [7:0] o_rx_data,
    output logic       o_rdy,
    output logic       o_start
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    rx_state_t        r_state;
    rx_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit_cnt;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_rdy;
    logic             w_fall;
    logic             w_tick;
    logic             w_start;
    logic             w_accept;

    assign w_fall = r_prev & ~r_sync2;
    assign w_tick = (r_cnt == CNT_W'(1));

    // Synchronizer and edge-detect history idle high so reset never fakes a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RX_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_start = 1'b1;
                    w_next  = RX_RECV;
                end
            end
            RX_RECV: begin
                if (w_tick && (r_bit_cnt == 4'd9)) begin
                    w_accept = r_sync2;
                    w_next   = RX_IDLE;
                end
            end
            default: w_next = RX_IDLE;
        endcase
    end

    // Nine shifts (start + 8 data) push the start bit out, leaving the data byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
        end else begin
            if (w_start) begin
                r_cnt     <= CNT_W'(BAUD_DIV / 2);
                r_bit_cnt <= '0;
            end else if (r_state == RX_RECV) begin
                if (w_tick) begin
                    r_cnt     <= CNT_W'(BAUD_DIV);
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt != 4'd9) r_shift <= {r_sync2, r_shift[7:1]};
                end else begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
            if (w_accept) r_data <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_rdy <= 1'b0;
        else if (w_accept)  r_rdy <= 1'b1;
        else if (i_clr_rdy) r_rdy <= 1'b0;
    end

    assign o_rx_data = r_data;
    assign o_rdy     = r_rdy;
    assign o_start   = w_start;

endmodule

// File: rtl/uart_tx.sv
// 8N1 transmitter: 10-bit frame shifter clocked by a baud down-counter.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_trmt,
    input  logic [7:0] i_tx_data,
    output logic       o_tx,
    output logic       o_tx_done
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);

    tx_state_t        r_state;
    tx_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit_cnt;
    logic [9:0]       r_shift;
    logic             r_tx_done;
    logic             w_tick;
    logic             w_load;
    logic             w_finish;

    assign w_tick = (r_cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_trmt) begin
                    w_load = 1'b1;
                    w_next = TXING;
                end
            end
            TXING: begin
                if (w_tick && (r_bit_cnt == 4'd9)) begin
                    w_finish = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Shifter resets to all ones and refills with ones, so its LSB is the idle-high line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '1;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
        end else if (w_load) begin
            r_shift   <= {1'b1, i_tx_data, 1'b0};
            r_cnt     <= CNT_W'(BAUD_DIV);
            r_bit_cnt <= '0;
        end else if (r_state == TXING) begin
            if (w_tick) begin
                r_shift   <= {1'b1, r_shift[9:1]};
                r_cnt     <= CNT_W'(BAUD_DIV);
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_tx_done <= 1'b0;
        else if (w_load)   r_tx_done <= 1'b0;
        else if (w_finish) r_tx_done <= 1'b1;
    end

    assign o_tx      = r_shift[0];
    assign o_tx_done = r_tx_done;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles two received bytes (high first) into a 16-bit command; forwards responses to TX.
module uart_cmd_wrapper
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    rx_asm_t     r_state;
    rx_asm_t     w_next;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;
    logic [7:0]  w_rx_data;
    logic        w_rx_rdy;
    logic        w_rx_start;
    logic        w_hi_en;
    logic        w_lo_en;

    UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rx      (RX),
        .o_tx      (TX),
        .o_rx_data (w_rx_data),
        .o_rdy     (w_rx_rdy),
        .i_clr_rdy (w_rx_rdy),
        .o_start   (w_rx_start),
        .i_trmt    (trmt),
        .i_tx_data (resp),
        .o_tx_done (tx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= HIGH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_hi_en = 1'b0;
        w_lo_en = 1'b0;
        case (r_state)
            HIGH: begin
                if (w_rx_rdy) begin
                    w_hi_en = 1'b1;
                    w_next  = LOW;
                end
            end
            LOW: begin
                if (w_rx_rdy) begin
                    w_lo_en = 1'b1;
                    w_next  = HIGH;
                end
            end
            default: w_next = HIGH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd <= 16'h0000;
        end else begin
            if (w_hi_en) r_cmd[15:8] <= w_rx_data;
            if (w_lo_en) r_cmd[7:0]  <= w_rx_data;
        end
    end

    // Completion beats any clear arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cmd_rdy <= 1'b0;
        else if (w_lo_en)
            r_cmd_rdy <= 1'b1;
        else if (clr_cmd_rdy || (w_rx_start && (r_state == HIGH)))
            r_cmd_rdy <= 1'b0;
    end

    assign cmd     = r_cmd;
    assign cmd_rdy = r_cmd_rdy;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper at BAUD_DIV=16 with a bit-banging RX driver.
module tb_uart_cmd_wrapper;
  import uart_pkg::*;

  localparam int B = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic        prev_rdy = 1'b0;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    int          gap_bits;
    logic [15:0] exp_cmd;
  } cmd_vec_t;

  cmd_vec_t vecs[4];

  always #5 clk = ~clk;

  uart_cmd_wrapper #(.BAUD_DIV(B)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .trmt        (trmt),
    .tx_done     (tx_done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Scoreboard: every rising cmd_rdy must present the oldest expected command.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rdy = 1'b0;
    end else begin
      if (cmd_rdy && !prev_rdy) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_cmd_rdy: got cmd %0h with no command outstanding", cmd);
        end else begin
          check("cmd_on_rdy", {16'h0, cmd}, {16'h0, exp_q.pop_front()});
        end
      end
      prev_rdy = cmd_rdy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // Driver tasks: all start and end on a falling clock edge.
  task automatic idle_bits(input int nbits);
    RX = 1'b1;
    repeat (nbits * B) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (B) @(negedge clk);
    end
  endtask

  task automatic send_cmd(input logic [15:0] c, input int gap_bits);
    send_byte(c[15:8], 1'b1);
    if (gap_bits > 0) idle_bits(gap_bits);
    send_byte(c[7:0], 1'b1);
  endtask

  task automatic wait_rdy(input string name);
    int i;
    i = 0;
    while (!cmd_rdy && i < 40) begin
      @(negedge clk);
      i++;
    end
    check(name, {31'h0, cmd_rdy}, 32'h1);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  // Transmit one response and compare the line against the frame built from resp.
  task automatic tx_run(input logic [7:0] r, input logic retrig);
    logic [9:0] f;
    logic       exp_tx;
    int         bad_tx;
    int         bad_done;
    f        = {1'b1, r, 1'b0};
    bad_tx   = 0;
    bad_done = 0;
    resp = r;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    for (int k = 0; k < 170; k++) begin
      exp_tx = (k < 160) ? f[k / B] : 1'b1;
      if (TX !== exp_tx) bad_tx++;
      if (tx_done !== (k >= 160)) bad_done++;
      if ((k % B) == (B / 2) && k < 160) check($sformatf("tx_bit%0d", k / B), {31'h0, TX}, {31'h0, exp_tx});
      if (k == 159) check("tx_done_before", {31'h0, tx_done}, 32'h0);
      if (k == 160) check("tx_done_at_160", {31'h0, tx_done}, 32'h1);
      if (retrig && k == 50) begin
        trmt = 1'b1;
        resp = ~r;
      end
      if (k == 51) trmt = 1'b0;
      @(negedge clk);
    end
    check("tx_wave_errors", bad_tx, 0);
    check("tx_done_errors", bad_done, 0);
  endtask

  initial begin
    logic [15:0] rc;
    int          tmo;

    vecs[0] = '{8'h40, 8'h01, 0, 16'h4001};
    vecs[1] = '{8'h00, 8'hFF, 1, 16'h00FF};
    vecs[2] = '{8'hFF, 8'h00, 0, 16'hFF00};
    vecs[3] = '{8'h81, 8'h7E, 3, 16'h817E};

    // Reset
    rst_n       = 1'b0;
    RX          = 1'b1;
    clr_cmd_rdy = 1'b0;
    trmt        = 1'b0;
    resp        = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, TX}, 32'h1);
    check("rst_cmd", {16'h0, cmd}, 32'h0);
    check("rst_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("rst_tx_done", {31'h0, tx_done}, 32'h0);
    rst_n = 1'b1;
    repeat (500) @(negedge clk);
    check("idle_tx", {31'h0, TX}, 32'h1);
    check("idle_cmd", {16'h0, cmd}, 32'h0);
    check("idle_cmd_rdy", {31'h0, cmd_rdy}, 32'h0);
    check("idle_tx_done", {31'h0, tx_done}, 32'h0);

    // Table-driven commands, each acknowledged
    for (int v = 0; v < 4; v++) begin
      exp_q.push_back(vecs[v].exp_cmd);
      send_cmd({vecs[v].hi, vecs[v].lo}, vecs[v].gap_bits);
      wait_rdy("vec_rdy");
      check("vec_cmd", {16'h0, cmd}, {16'h0, vecs[v].exp_cmd});
      pulse_clr();
      check("vec_clr", {31'h0, cmd_rdy}, 32'h0);
      check("vec_cmd_hold", {16'h0, cmd}, {16'h0, vecs[v].exp_cmd});
    end

    // Back-to-back commands without acknowledge
    exp_q.push_back(16'h2000);
    send_cmd(16'h2000, 0);
    check("b2b_first_rdy", {31'h0, cmd_rdy}, 32'h1);
    exp_q.push_back(16'h5BFF);
    fork
      send_byte(8'h5B, 1'b1);
      begin
        repeat (2 * B) @(negedge clk);
        check("b2b_rdy_drop", {31'h0, cmd_rdy}, 32'h0);
      end
    join
    send_byte(8'hFF, 1'b1);
    wait_rdy("b2b_second_rdy");
    check("b2b_cmd", {16'h0, cmd}, 32'h5BFF);
    pulse_clr();

    // Framing error: bad frame is discarded and the FSM stays on the high byte
    send_byte(8'h40, 1'b0);
    idle_bits(2);
    check("ferr_no_rdy", {31'h0, cmd_rdy}, 32'h0);
    send_byte(8'h12, 1'b1);
    idle_bits(1);
    check("ferr_hi_byte", {24'h0, cmd[15:8]}, 32'h12);
    check("ferr_hi_no_rdy", {31'h0, cmd_rdy}, 32'h0);
    exp_q.push_back(16'h1234);
    send_byte(8'h34, 1'b1);
    wait_rdy("ferr_rdy");
    check("ferr_cmd", {16'h0, cmd}, 32'h1234);

    // Response transmit with an ignored retrigger at clock 50
    tx_run(POS_ACK, 1'b1);

    // Full duplex with a set/clear collision on low-byte completion
    exp_q.push_back(16'hA55A);
    fork
      send_cmd(16'hA55A, 0);
      tx_run(8'h5A, 1'b0);
      begin
        repeat (19 * B) @(negedge clk);
        clr_cmd_rdy = 1'b1;
        tmo = 0;
        while (!cmd_rdy && tmo < 40) begin
          @(negedge clk);
          tmo++;
        end
        clr_cmd_rdy = 1'b0;
        check("collide_rise", {31'h0, cmd_rdy}, 32'h1);
      end
    join
    repeat (2) @(negedge clk);
    check("collide_rdy_held", {31'h0, cmd_rdy}, 32'h1);
    check("duplex_cmd", {16'h0, cmd}, 32'hA55A);
    pulse_clr();

    // Randomized commands checked against {high, low} of what was sent
    for (int r = 0; r < 6; r++) begin
      rc = 16'($urandom);
      exp_q.push_back(rc);
      send_cmd(rc, $urandom_range(0, 2));
      wait_rdy("rand_rdy");
      check("rand_cmd", {16'h0, cmd}, {16'h0, rc});
      pulse_clr();
      check("rand_clr", {31'h0, cmd_rdy}, 32'h0);
      idle_bits($urandom_range(0, 1));
    end
    for (int r = 0; r < 3; r++) tx_run(8'($urandom_range(0, 255)), 1'b0);

    // Asynchronous reset in the middle of a transmitted frame
    resp = 8'h00;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_reset_tx", {31'h0, TX}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_tx", {31'h0, TX}, 32'h1);
    check("async_reset_cmd", {16'h0, cmd}, 32'h0);
    check("async_reset_done", {31'h0, tx_done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
